// File: rtl/register_file.sv
// Architectural register file with RoB-index renaming.
// Holds one value, one busy flag and one producing-RoB-index tag per register.
// Both read ports are combinational. When a matching commit is on the commit
// port in the same cycle, the read returns the committed value directly.
module register_file #(
    parameter int RoB_WIDTH = 3,
    parameter int REG_NUM   = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 rename_en,
    input  logic [4:0]           rename_rd,
    input  logic [RoB_WIDTH-1:0] rename_index,
    input  logic                 commit_en,
    input  logic [4:0]           commit_reg,
    input  logic [RoB_WIDTH-1:0] commit_index,
    input  logic [31:0]          commit_data,
    input  logic [4:0]           rs1_reg,
    input  logic [4:0]           rs2_reg,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [RoB_WIDTH-1:0] rs1_dep,
    output logic [RoB_WIDTH-1:0] rs2_dep,
    output logic [31:0]          rs1_val,
    output logic [31:0]          rs2_val
);

    typedef struct packed {
        logic                 busy;
        logic [RoB_WIDTH-1:0] dep;
        logic [31:0]          val;
    } operand_t;

    logic [31:0]          regs [REG_NUM];
    logic                 busy [REG_NUM];
    logic [RoB_WIDTH-1:0] dep  [REG_NUM];

    logic commit_fire;
    logic rename_fire;
    logic commit_clears;

    operand_t rs1_op;
    operand_t rs2_op;

    assign commit_fire = rdy_in && commit_en && (commit_reg != 5'd0);
    assign rename_fire = rdy_in && !flush_in && rename_en && (rename_rd != 5'd0);

    // A commit releases its register only when it is the newest producer.
    // A same-cycle rename of that register takes priority and keeps it busy.
    assign commit_clears = commit_fire
                        && busy[commit_reg]
                        && (dep[commit_reg] == commit_index)
                        && !(rename_fire && (rename_rd == commit_reg));

    // Operand lookup. x0 reads zero. A matching commit is forwarded in the same
    // cycle. The instruction's own rd rename is not forwarded, because operands
    // are read before that rename takes effect.
    function automatic operand_t lookup(input logic [4:0] rs);
        operand_t op;
        op = '0;
        if (rs != 5'd0) begin
            op.busy = busy[rs];
            op.dep  = dep[rs];
            op.val  = regs[rs];
            if (busy[rs] && commit_en && rdy_in &&
                (commit_reg == rs) && (commit_index == dep[rs])) begin
                op.busy = 1'b0;
                op.val  = commit_data;
            end
        end
        return op;
    endfunction

    // Combinational read ports
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path leaves it unassigned and infers a latch.
        rs1_op   = lookup(rs1_reg);
        rs2_op   = lookup(rs2_reg);
        rs1_busy = rs1_op.busy;
        rs1_dep  = rs1_op.dep;
        rs1_val  = rs1_op.val;
        rs2_busy = rs2_op.busy;
        rs2_dep  = rs2_op.dep;
        rs2_val  = rs2_op.val;
    end

    // Value array. A commit always writes its value, even during a flush,
    // because the instruction has architecturally retired.
    always_ff @(posedge clk_in or negedge rst_in) begin
        // NOTE: the whole array is reset here because every read must return 0 after reset. This keeps it out of block RAM on purpose.
        if (!rst_in) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (commit_fire) begin
            // NOTE: sequential state uses non-blocking assignments so that every process sees pre-edge values.
            regs[commit_reg] <= commit_data;
        end
    end

    // Dependency tracking: a flush clears all tags, a commit releases its
    // register, and a rename claims its register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                busy[i] <= 1'b0;
                dep[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    busy[i] <= 1'b0;
                    dep[i]  <= '0;
                end
            end else begin
                if (commit_clears) busy[commit_reg] <= 1'b0;
                if (rename_fire) begin
                    busy[rename_rd] <= 1'b1;
                    dep[rename_rd]  <= rename_index;
                end
            end
        end
    end

endmodule
